maxpool2x2_stream: RTL and testbench

- Streaming 2x2, stride-2 max-pooling stage placed directly downstream of the per-pixel ReLU unit in the CNN datapath.
- Consumes one unsigned activation per valid cycle in raster order (row-major, one channel plane per frame).
- Emits one pooled activation per 2x2 window.
- Holds partial row maxima in an internal line buffer of IMG_WIDTH/2 entries.

---
 rtl/cnn_pkg.sv | 28 ++
 rtl/pool_line_buffer.sv | 39 +++
 rtl/maxpool2x2_stream.sv | 151 +++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath types, constants and helpers
//
// Contents:
//   CNN_DATA_WIDTH : default activation width (unsigned, matches ReLU output)
//   MAX_WIDTH      : widest operand accepted by the compare helpers
//   pixel_t        : default-width activation type
//   max2()         : unsigned two-input maximum, shared by all pooling stages

package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 8;

  // Compare helpers operate at this width. Callers zero-extend their operands
  // and truncate the result, so a single function serves every DATA_WIDTH
  // up to this bound.
  localparam int MAX_WIDTH = 32;

  typedef logic [CNN_DATA_WIDTH-1:0] pixel_t;

  // Unsigned maximum. On a tie either operand is correct; a is returned.
  function automatic logic [MAX_WIDTH-1:0] max2(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// rtl/pool_line_buffer.sv - simple dual-port line buffer for partial row maxima
//
// Ports:
//   clk      : write clock
//   wr_en    : write strobe, sampled on the rising edge of clk
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : combinational read data
//
// The read is asynchronous so that the pooling stage can combine the stored
// top-row maximum with the current bottom-row pixels in the same cycle and
// still meet its one-cycle output latency. Contents are not reset: every
// entry is written on an even row before it is read on the following odd row.

module pool_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 max-pooling stage
//
// Ports:
//   clk         : single clock, all state on the rising edge
//   rst_n       : asynchronous active-low reset
//   enable      : stage enable; when low, inputs are ignored and state holds
//   sync_clear  : synchronous frame abort; zeroes counters and partial state
//   in_data     : unsigned activation, raster order, one plane per frame
//   in_valid    : in_data valid this cycle
//   out_data    : pooled activation (holds its last value between outputs)
//   out_valid   : one-cycle pulse per pooled output
//   frame_done  : one-cycle pulse coincident with the last output of a frame
//
// Per accepted pixel at (row, col):
//   even col            : h_reg captures the pixel (left half of the pair)
//   even row, odd col   : linebuf[col/2] <= max(h_reg, pixel)
//   odd row,  odd col   : out_data <= max(linebuf[col/2], h_reg, pixel)
// No backpressure: downstream must take out_data on every out_valid cycle.

module maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  sync_clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  frame_done
);

  localparam int HALF_W = IMG_WIDTH / 2;
  localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int IDX_W  = (HALF_W     > 1) ? $clog2(HALF_W)     : 1;

  // Odd or degenerate planes cannot be tiled by 2x2 windows.
  generate
    if ((IMG_WIDTH < 2) || ((IMG_WIDTH % 2) != 0)) begin : g_bad_width
      $error("maxpool2x2_stream: IMG_WIDTH must be even and >= 2");
    end
    if ((IMG_HEIGHT < 2) || ((IMG_HEIGHT % 2) != 0)) begin : g_bad_height
      $error("maxpool2x2_stream: IMG_HEIGHT must be even and >= 2");
    end
    if ((DATA_WIDTH < 1) || (DATA_WIDTH > MAX_WIDTH)) begin : g_bad_data
      $error("maxpool2x2_stream: DATA_WIDTH out of range for max2");
    end
  endgenerate

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] h_reg;

  logic                  accept;
  logic                  col_last;
  logic                  row_last;
  logic                  col_odd;
  logic                  row_odd;
  logic [IDX_W-1:0]      idx;
  logic                  lb_we;
  logic [DATA_WIDTH-1:0] lb_rd_data;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] window_max;

  // sync_clear has priority over a simultaneous pixel, which is dropped.
  assign accept   = enable && in_valid && !sync_clear;
  assign col_last = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));
  assign col_odd  = col[0];
  assign row_odd  = row[0];
  assign idx      = IDX_W'(col >> 1);

  // Horizontal maximum of the current pixel pair; on an even row this is
  // the top half of the window, on an odd row it joins the stored top half.
  assign pair_max   = DATA_WIDTH'(max2(MAX_WIDTH'(h_reg), MAX_WIDTH'(in_data)));
  assign window_max = DATA_WIDTH'(max2(MAX_WIDTH'(lb_rd_data), MAX_WIDTH'(pair_max)));

  assign lb_we = accept && col_odd && !row_odd;

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HALF_W),
    .ADDR_WIDTH (IDX_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_addr (idx),
    .wr_data (pair_max),
    .rd_addr (idx),
    .rd_data (lb_rd_data)
  );

  // Raster position. The row wraps with the last pixel of the frame so a
  // following frame can start on the very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (sync_clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Left pixel of the current horizontal pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg <= '0;
    end else if (sync_clear) begin
      h_reg <= '0;
    end else if (accept && !col_odd) begin
      h_reg <= in_data;
    end
  end

  // Output register: out_valid/frame_done are single-cycle pulses, while
  // out_data keeps the last pooled value until the next window completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (accept && col_odd && row_odd) begin
        out_data   <= window_max;
        out_valid  <= 1'b1;
        frame_done <= col_last && row_last;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - self-checking bench for maxpool2x2_stream
module tb_maxpool2x2_stream;
  import cnn_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic   clk = 1'b0;
  logic   rst_n = 1'b1;
  logic   enable = 1'b0;
  logic   sync_clear = 1'b0;
  logic   in_valid = 1'b0;
  pixel_t in_data = '0;
  pixel_t out_data;
  logic   out_valid;
  logic   frame_done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic   en;
    logic   vl;
    logic   cl;
    pixel_t d;
    logic   ev;
    logic   chk_d;
    pixel_t ed;
    logic   efd;
  } vec_t;

  vec_t tbl[$];

  maxpool2x2_stream #(
    .DATA_WIDTH (8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sync_clear (sync_clear),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic run_vec(input vec_t v, input string nm);
    enable     = v.en;
    in_valid   = v.vl;
    sync_clear = v.cl;
    in_data    = v.d;
    @(posedge clk);
    #1;
    check({nm, "_valid"}, {31'd0, out_valid}, {31'd0, v.ev});
    check({nm, "_done"}, {31'd0, frame_done}, {31'd0, v.efd});
    if (v.chk_d) check({nm, "_data"}, {24'd0, out_data}, {24'd0, v.ed});
  endtask

  task automatic run_table(input string nm);
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("%s[%0d]", nm, i));
    tbl.delete();
    enable = 1'b0; in_valid = 1'b0; sync_clear = 1'b0;
  endtask

  function automatic vec_t mk(input logic en, input logic vl, input logic cl, input pixel_t d,
                              input logic ev, input logic chk_d, input pixel_t ed, input logic efd);
    vec_t v;
    v.en = en; v.vl = vl; v.cl = cl; v.d = d;
    v.ev = ev; v.chk_d = chk_d; v.ed = ed; v.efd = efd;
    return v;
  endfunction

  // Ramp pixel i of a 4x4 frame; window maxima are the bottom-right pixels
  // at indices 5, 7, 13, 15, and index 15 closes the frame.
  function automatic vec_t ramp_px(input int base, input int i);
    logic win;
    win = (i == 5) || (i == 7) || (i == 13) || (i == 15);
    return mk(1'b1, 1'b1, 1'b0, pixel_t'(base + i), win, win, pixel_t'(base + i), i == 15);
  endfunction

  function automatic void push_ramp(input int base);
    for (int i = 0; i < 16; i++) tbl.push_back(ramp_px(base, i));
  endfunction

  initial begin
    pixel_t sp_exp [4];
    int     sp_slot;
    sp_exp = '{8'd200, 8'd0, 8'd0, 8'd255};

    // Reset state, asserted before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_done", {31'd0, frame_done}, 32'd0);
    check("reset_data", {24'd0, out_data}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp frame.
    push_ramp(0);
    run_table("ramp");

    // Sparse frame: (1,0)=200 is index 4, (2,3)=255 is index 11.
    sp_slot = 0;
    for (int i = 0; i < 16; i++) begin
      logic win;
      pixel_t d;
      win = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      d = (i == 4) ? 8'd200 : (i == 11) ? 8'd255 : 8'd0;
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, d, win, win, win ? sp_exp[sp_slot] : 8'd0, i == 15));
      if (win) sp_slot++;
    end
    run_table("sparse");

    // Ramp with stalls: in_valid low after pixel 2, enable low (with junk
    // data on a valid input) after pixel 5, in_valid low after pixel 11.
    // out_data must hold the previous pooled value through each stall.
    for (int i = 0; i < 16; i++) begin
      tbl.push_back(ramp_px(0, i));
      if (i == 2)  tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'd77,  1'b0, 1'b1, 8'd255, 1'b0));
      if (i == 5)  tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'd250, 1'b0, 1'b1, 8'd5,   1'b0));
      if (i == 11) tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'd99,  1'b0, 1'b1, 8'd7,   1'b0));
    end
    run_table("stall");

    // Two back-to-back frames, no idle cycle between them.
    push_ramp(0);
    push_ramp(100);
    run_table("b2b");

    // Six pixels (the first window completes at pixel 5 with value 45),
    // then sync_clear with a valid pixel that must be dropped, then a
    // clean ramp frame that must pool from (0,0).
    for (int i = 0; i < 6; i++) tbl.push_back(ramp_px(40, i));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 8'd99, 1'b0, 1'b1, 8'd45, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 8'd98, 1'b0, 1'b1, 8'd45, 1'b0));
    push_ramp(0);
    run_table("clear");

    // Mid-frame asynchronous reset right after an output pulse.
    for (int i = 0; i < 6; i++) tbl.push_back(ramp_px(60, i));
    run_table("prereset");
    check("prereset_hold", {24'd0, out_data}, 32'd65);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_done", {31'd0, frame_done}, 32'd0);
    check("midreset_data", {24'd0, out_data}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("postreset_valid", {31'd0, out_valid}, 32'd0);
    check("postreset_data", {24'd0, out_data}, 32'd0);
    push_ramp(0);
    run_table("afterreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
